// File: rtl/sram_slave.sv
// Memory bus slave: DEPTH x DWIDTH array, programmable wait states, four-phase ready handshake.
// Optional write protection below PROT_LIMIT is enabled by defining SRAM_WR_PROTECT_EN.
module sram_slave #(
  parameter int DWIDTH      = 16,
  parameter int AWIDTH      = 12,
  parameter int DEPTH       = 4096,
  parameter int WAIT_CYCLES = 1,
  parameter int PROT_LIMIT  = 16
) (
  input  logic              clk,
  input  logic              i_rst_n,
  input  logic              i_ce,
  input  logic              i_we,
  input  logic [AWIDTH-1:0] i_addr,
  input  logic [DWIDTH-1:0] i_data,
  output logic [DWIDTH-1:0] o_data,
  output logic              o_ready,
  output logic              o_busy,
  output logic              o_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP,
    S_RELEASE
  } state_t;

  if (DEPTH != (1 << AWIDTH)) begin : g_bad_depth
    $error("sram_slave: DEPTH must equal 1<<AWIDTH");
  end
  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
    $error("sram_slave: WAIT_CYCLES must be in 0..15");
  end
  if (PROT_LIMIT < 0 || PROT_LIMIT > DEPTH) begin : g_bad_prot
    $error("sram_slave: PROT_LIMIT must be in 0..DEPTH");
  end

  state_t              state;
  logic [3:0]          cnt;
  logic [AWIDTH-1:0]   addr_q;
  logic [DWIDTH-1:0]   data_q;
  logic                we_q;
  logic                prot;
  logic                commit;
  logic [DWIDTH-1:0]   mem [DEPTH];

`ifdef SRAM_WR_PROTECT_EN
  localparam logic [AWIDTH:0] PROT_ADDR = (AWIDTH+1)'(PROT_LIMIT);
  assign prot = ({1'b0, addr_q} < PROT_ADDR);
`else
  assign prot = 1'b0;
`endif

  // The write lands on the same edge the FSM leaves WAIT, so a reset before then drops it.
  assign commit = (state == S_WAIT) && (cnt == 4'd0) && we_q && !prot;

  // NOTE: the array has no reset branch; contents survive reset and it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (commit) mem[addr_q] <= data_q;
  end

  // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= S_IDLE;
      cnt     <= 4'd0;
      addr_q  <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      o_data  <= '0;
      o_ready <= 1'b0;
      o_busy  <= 1'b0;
      o_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_ce) begin
            addr_q <= i_addr;
            data_q <= i_data;
            we_q   <= i_we;
            cnt    <= 4'(WAIT_CYCLES);
            state  <= S_WAIT;
            o_busy <= 1'b1;
          end
        end
        S_WAIT: begin
          if (cnt == 4'd0) begin
            if (!we_q) o_data <= mem[addr_q];
            o_err   <= we_q && prot;
            o_ready <= 1'b1;
            state   <= S_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_RESP, S_RELEASE: begin
          // Holding ce high parks in RELEASE so one ce pulse yields exactly one access.
          if (!i_ce) begin
            state   <= S_IDLE;
            o_ready <= 1'b0;
            o_busy  <= 1'b0;
            o_err   <= 1'b0;
          end else begin
            state <= S_RELEASE;
          end
        end
        default: begin
          state   <= S_IDLE;
          o_ready <= 1'b0;
          o_busy  <= 1'b0;
          o_err   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_slave.sv
// Directed, table-driven bench for sram_slave: handshake latency, readback, held ce,
// reset mid-access, WAIT-phase input changes and (with SRAM_WR_PROTECT_EN) write protection.
module tb_sram_slave;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ce = 1'b0;
  logic        ce_x = 1'b0;
  logic        we = 1'b0;
  logic [11:0] addr = '0;
  logic [15:0] data = '0;

  logic [15:0] rdata, rdata0, rdata3;
  logic        ready, ready0, ready3;
  logic        busy, busy0, busy3;
  logic        err, err0, err3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram_slave dut (
    .clk(clk), .i_rst_n(rst_n), .i_ce(ce), .i_we(we), .i_addr(addr), .i_data(data),
    .o_data(rdata), .o_ready(ready), .o_busy(busy), .o_err(err)
  );

  sram_slave #(.WAIT_CYCLES(0)) dut0 (
    .clk(clk), .i_rst_n(rst_n), .i_ce(ce_x), .i_we(we), .i_addr(addr), .i_data(data),
    .o_data(rdata0), .o_ready(ready0), .o_busy(busy0), .o_err(err0)
  );

  sram_slave #(.WAIT_CYCLES(3)) dut3 (
    .clk(clk), .i_rst_n(rst_n), .i_ce(ce_x), .i_we(we), .i_addr(addr), .i_data(data),
    .o_data(rdata3), .o_ready(ready3), .o_busy(busy3), .o_err(err3)
  );

  typedef struct {
    logic        we;
    logic [11:0] addr;
    logic [15:0] data;
    logic [15:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full request on the default-latency instance; returns latency, data and error seen with ready.
  task automatic do_access(input logic w, input logic [11:0] a, input logic [15:0] d,
                           output int lat, output logic [15:0] rd, output logic er);
    ce = 1'b1; we = w; addr = a; data = d;
    tick();
    check("busy_after_accept", 32'(busy), 32'd1);
    lat = 0;
    while (!ready && lat < 20) begin
      tick();
      lat++;
    end
    rd = rdata;
    er = err;
    ce = 1'b0;
    tick();
    check("ready_drop", 32'(ready), 32'd0);
    check("busy_drop", 32'(busy), 32'd0);
  endtask

  vec_t        tbl [11];
  int          lat, l0, l3, held;
  logic [15:0] rd, last_rd;
  logic        er;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{1'b1, 12'h020, 16'h1234, 16'h0000};
    tbl[1]  = '{1'b0, 12'h020, 16'h0000, 16'h1234};
    tbl[2]  = '{1'b1, 12'h000, 16'h0001, 16'h0000};
    tbl[3]  = '{1'b1, 12'hFFF, 16'hBEEF, 16'h0000};
    tbl[4]  = '{1'b0, 12'h000, 16'h0000, 16'h0001};
    tbl[5]  = '{1'b0, 12'hFFF, 16'h0000, 16'hBEEF};
    tbl[6]  = '{1'b1, 12'h040, 16'h1111, 16'h0000};
    tbl[7]  = '{1'b1, 12'h051, 16'h0051, 16'h0000};
    tbl[8]  = '{1'b1, 12'h020, 16'h5A5A, 16'h0000};
    tbl[9]  = '{1'b0, 12'h020, 16'h0000, 16'h5A5A};
    tbl[10] = '{1'b0, 12'h040, 16'h0000, 16'h1111};

    // Reset state
    #12;
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_data", 32'(rdata), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Table: writes leave o_data at the last read value
    last_rd = 16'h0000;
    for (int i = 0; i < 11; i++) begin
      do_access(tbl[i].we, tbl[i].addr, tbl[i].data, lat, rd, er);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd2);
      check($sformatf("vec%0d_err", i), 32'(er), 32'd0);
      if (!tbl[i].we) last_rd = tbl[i].exp;
      check($sformatf("vec%0d_data", i), 32'(rd), 32'(last_rd));
    end

    // ce held for 6 clocks after ready, data changed meanwhile: single write only
    ce = 1'b1; we = 1'b1; addr = 12'h030; data = 16'hAAAA;
    tick();
    lat = 0;
    while (!ready && lat < 20) begin tick(); lat++; end
    check("held_latency", 32'(lat), 32'd2);
    held = 0;
    for (int i = 0; i < 6; i++) begin
      if (i == 3) data = 16'h5555;
      tick();
      if (ready && busy) held++;
    end
    check("held_ready_cycles", 32'(held), 32'd6);
    data = 16'h5555;
    ce = 1'b0;
    tick();
    check("held_ready_drop", 32'(ready), 32'd0);
    check("held_busy_drop", 32'(busy), 32'd0);
    do_access(1'b0, 12'h030, 16'h0000, lat, rd, er);
    check("held_readback", 32'(rd), 32'hAAAA);

    // Inputs changed during WAIT are ignored
    ce = 1'b1; we = 1'b1; addr = 12'h050; data = 16'h7777;
    tick();
    addr = 12'h051; data = 16'h9999; we = 1'b0;
    lat = 0;
    while (!ready && lat < 20) begin tick(); lat++; end
    check("waitchg_latency", 32'(lat), 32'd2);
    check("waitchg_wdata_no_odata", 32'(rdata), 32'hAAAA);
    ce = 1'b0;
    tick();
    do_access(1'b0, 12'h050, 16'h0000, lat, rd, er);
    check("waitchg_target", 32'(rd), 32'h7777);
    do_access(1'b0, 12'h051, 16'h0000, lat, rd, er);
    check("waitchg_other_addr", 32'(rd), 32'h0051);

    // Latency for WAIT_CYCLES = 0 and 3 on 0xFFF
    ce_x = 1'b1; we = 1'b1; addr = 12'hFFF; data = 16'hBEEF;
    tick();
    lat = 0;
    while (!(ready0 && ready3) && lat < 20) begin tick(); lat++; end
    check("wx_write_done", 32'(ready0 && ready3), 32'd1);
    ce_x = 1'b0;
    tick();
    ce_x = 1'b1; we = 1'b0; addr = 12'hFFF; data = 16'h0000;
    tick();
    l0 = 0; l3 = 0;
    for (int t = 1; t <= 10; t++) begin
      tick();
      if (ready0 && l0 == 0) l0 = t;
      if (ready3 && l3 == 0) l3 = t;
    end
    check("w0_latency", 32'(l0), 32'd1);
    check("w3_latency", 32'(l3), 32'd4);
    check("w0_data", 32'(rdata0), 32'hBEEF);
    check("w3_data", 32'(rdata3), 32'hBEEF);
    ce_x = 1'b0;
    tick();
    check("wx_ready_drop", 32'(ready0 | ready3), 32'd0);

    // Reset during WAIT of a write abandons it
    do_access(1'b0, 12'h040, 16'h0000, lat, rd, er);
    check("pre_rst_read", 32'(rd), 32'h1111);
    ce = 1'b1; we = 1'b1; addr = 12'h040; data = 16'h0F0F;
    tick();
    check("rst_mid_busy_before", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_ready", 32'(ready), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_data", 32'(rdata), 32'd0);
    ce = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    do_access(1'b0, 12'h040, 16'h0000, lat, rd, er);
    check("rst_mid_readback", 32'(rd), 32'h1111);

`ifdef SRAM_WR_PROTECT_EN
    do_access(1'b1, 12'h005, 16'hDEAD, lat, rd, er);
    check("prot_low_err", 32'(er), 32'd1);
    do_access(1'b0, 12'h005, 16'h0000, lat, rd, er);
    check("prot_low_unchanged", 32'(rd == 16'hDEAD), 32'd0);
    check("prot_low_read_err", 32'(er), 32'd0);
    do_access(1'b1, 12'h010, 16'hDEAD, lat, rd, er);
    check("prot_limit_err", 32'(er), 32'd0);
    do_access(1'b0, 12'h010, 16'h0000, lat, rd, er);
    check("prot_limit_readback", 32'(rd), 32'hDEAD);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_slave.md
Name: sram_slave

Overview:
- Memory responder on the CPU datapath's memory bus: the slave end of the ce/we/addr/data interface the datapath drives.
- Holds a DEPTH x DWIDTH word array.
- Accepts one read or write per request, inserts a programmable number of wait states, and answers with a four-phase ready handshake.
- Sits between the datapath and the behavioural memory image.

Parameters:
- DWIDTH, 16, data word width
- AWIDTH, 12, address width
- DEPTH, 4096, number of words (must equal 1<<AWIDTH)
- WAIT_CYCLES, 1, wait states inserted before an access completes (0..15)
- PROT_LIMIT, 16, first writable address (used only with the optional feature)

Ports:
- clk  input  1  clock, all state updates on rising edge
- i_rst_n  input  1  asynchronous active-low reset
- i_ce  input  1  chip enable / request, held high by master until o_ready seen
- i_we  input  1  1 = write, 0 = read; sampled at acceptance
- i_addr  input  AWIDTH  word address; sampled at acceptance
- i_data  input  DWIDTH  write data; sampled at acceptance
- o_data  output  DWIDTH  read data, registered
- o_ready  output  1  access complete; level, held until i_ce low
- o_busy  output  1  high in any state other than IDLE
- o_err  output  1  write-protect violation flag, valid with o_ready

Behaviour:
- Reset (i_rst_n low, asynchronous):
  - state = IDLE; o_data = 0, o_ready = 0, o_busy = 0, o_err = 0; wait counter = 0.
  - Array contents are not cleared.
  - Reset mid-access abandons the request; a write not yet committed never reaches the array.
- States: IDLE, WAIT, RESP, RELEASE.
- IDLE:
  - On an edge with i_ce = 1: latch i_addr, i_data, i_we; counter <= WAIT_CYCLES; go WAIT.
  - i_ce = 0: stay in IDLE.
- WAIT:
  - Each edge: if counter == 0, perform the access and go RESP; else counter <= counter - 1.
  - i_ce, i_we, i_addr and i_data are ignored while in WAIT; only latched values are used.
- Access:
  - Read: o_data <= mem[addr].
  - Write: mem[addr] <= data; o_data is unchanged.
- Latency: o_ready rises WAIT_CYCLES+1 clocks after the acceptance edge (2 clocks at default).
- RESP:
  - o_ready = 1.
  - Next edge: if i_ce = 0, go IDLE with o_ready <= 0; else go RELEASE (o_ready stays 1).
- RELEASE:
  - o_ready = 1 until an edge sees i_ce = 0, then IDLE with o_ready <= 0.
  - Guarantees one access per ce pulse; a ce held high never causes a duplicate access.
- Next request: accepted no earlier than the edge after returning to IDLE. Back-to-back requests need ce low for at least one sampled edge.
- o_busy = (state != IDLE), registered together with the state.
- Address: full AWIDTH range valid, no wrap logic needed. Data width is exact; no extension or truncation.
- Read-after-write to the same address in consecutive requests returns the new data.

Optional Feature:
- Macro: SRAM_WR_PROTECT_EN
- With macro defined:
  - A write with latched addr < PROT_LIMIT is not committed; the array is unchanged.
  - o_err = 1 from RESP through RELEASE for that request, cleared on return to IDLE.
  - Reads of protected addresses are normal, o_err = 0.
- Without macro: all writes commit; o_err tied 0; PROT_LIMIT unused.

Test Plan:
- Reset, then write 0x1234 to addr 0x020 (ce high until ready), then read 0x020 -> o_ready rises 2 clocks after each acceptance edge; read o_data = 0x1234; o_busy high only during transactions.
- Hold i_ce high for 6 clocks after o_ready on a write of 0xAAAA to 0x030, then change i_data to 0x5555 -> exactly one write; subsequent read of 0x030 = 0xAAAA; o_ready stays high until ce drops, low one clock after.
- WAIT_CYCLES = 0 and WAIT_CYCLES = 3 builds, read addr 0xFFF preloaded with 0xBEEF -> o_ready at 1 and 4 clocks after acceptance respectively; o_data = 0xBEEF.
- Pull i_rst_n low during WAIT of a write of 0x0F0F to 0x040 (old value 0x1111) -> o_ready/o_busy/o_data drop to 0 immediately; later read of 0x040 = 0x1111.
- Change i_addr/i_data during WAIT of a write to 0x050 (value 0x7777) -> array gets 0x7777 at 0x050; the new address is untouched.
- SRAM_WR_PROTECT_EN, PROT_LIMIT = 16: write 0xDEAD to 0x005 -> o_err = 1 with o_ready, readback unchanged; write 0xDEAD to 0x010 -> o_err = 0, readback 0xDEAD.
